// File: rtl/alu_reservation_station_pkg.sv
// Shared definitions for the ALU reservation station: default sizes and the
// operation-code encoding carried on the ALU bundle.
package alu_reservation_station_pkg;

  localparam int unsigned DEF_RS_SIZE   = 16;
  localparam int unsigned DEF_RS_IDX_W  = 4;
  localparam int unsigned DEF_ROB_TAG_W = 4;

  typedef enum logic [5:0] {
    OP_NOP   = 6'd0,
    OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
    OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
    OP_SB, OP_SH, OP_SW,
    OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI,
    OP_SLLI, OP_SRLI, OP_SRAI,
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU,
    OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND
  } opera_e;

endpackage

// File: rtl/alu_reservation_station_priority_encoder.sv
// Lowest-set-bit finder used for both the free-slot and ready-slot searches.
module rs_priority_encoder #(
  parameter int unsigned N = 16,
  parameter int unsigned W = 4
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic         found
);

  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (vec[i] && !found) begin
        idx   = W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_reservation_station.sv
// ALU reservation station: buffers dispatched ALU ops, snoops both CDB ports
// for operands and hands one ready entry per cycle to the ALU.
module alu_reservation_station
  import alu_reservation_station_pkg::*;
#(
  parameter int unsigned RS_SIZE   = DEF_RS_SIZE,
  parameter int unsigned RS_IDX_W  = DEF_RS_IDX_W,
  parameter int unsigned ROB_TAG_W = DEF_ROB_TAG_W
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 clear,

  input  logic                 issue_valid,
  input  logic [5:0]           issue_op,
  input  logic [31:0]          issue_instruction,
  input  logic [31:0]          issue_pc,
  input  logic [31:0]          issue_imm,
  input  logic [31:0]          issue_vj,
  input  logic [31:0]          issue_vk,
  input  logic                 issue_qj_busy,
  input  logic                 issue_qk_busy,
  input  logic [ROB_TAG_W-1:0] issue_qj,
  input  logic [ROB_TAG_W-1:0] issue_qk,
  input  logic [ROB_TAG_W-1:0] issue_entry,
  output logic                 rs_full,

  input  logic                 alu_broadcast,
  input  logic [31:0]          alu_result,
  input  logic [ROB_TAG_W-1:0] alu_entry,
  input  logic                 lsb_broadcast,
  input  logic [31:0]          lsb_result,
  input  logic [ROB_TAG_W-1:0] lsb_entry,

  output logic                 new_calculate,
  output logic [5:0]           op_out,
  output logic [31:0]          instruction_out,
  output logic [31:0]          vj_out,
  output logic [31:0]          vk_out,
  output logic [31:0]          pc_out,
  output logic [31:0]          imm_out,
  output logic [ROB_TAG_W-1:0] entry_out
);

  logic [RS_SIZE-1:0]   busy, qj_busy, qk_busy;
  logic [ROB_TAG_W-1:0] qj [RS_SIZE];
  logic [ROB_TAG_W-1:0] qk [RS_SIZE];
  logic [ROB_TAG_W-1:0] dest [RS_SIZE];
  logic [31:0]          vj [RS_SIZE];
  logic [31:0]          vk [RS_SIZE];
  logic [31:0]          pc [RS_SIZE];
  logic [31:0]          imm [RS_SIZE];
  logic [31:0]          instr [RS_SIZE];
  logic [5:0]           op [RS_SIZE];

  logic [RS_SIZE-1:0]   free_vec, ready_vec;
  logic [RS_IDX_W-1:0]  free_idx, sel_idx;
  logic                 free_found, sel_found;

  logic [31:0]          fwd_vj, fwd_vk;
  logic                 fwd_qj_busy, fwd_qk_busy;

  assign free_vec  = ~busy;
  assign ready_vec = busy & ~qj_busy & ~qk_busy;
  assign rs_full   = ~free_found;

  rs_priority_encoder #(.N(RS_SIZE), .W(RS_IDX_W)) u_free_enc (
    .vec   (free_vec),
    .idx   (free_idx),
    .found (free_found)
  );

  rs_priority_encoder #(.N(RS_SIZE), .W(RS_IDX_W)) u_ready_enc (
    .vec   (ready_vec),
    .idx   (sel_idx),
    .found (sel_found)
  );

  // Operand forwarding for a result broadcast in the same cycle as issue.
  always_comb begin
    fwd_vj      = issue_vj;
    fwd_qj_busy = issue_qj_busy;
    fwd_vk      = issue_vk;
    fwd_qk_busy = issue_qk_busy;
    if (issue_qj_busy && alu_broadcast && alu_entry == issue_qj) begin
      fwd_vj      = alu_result;
      fwd_qj_busy = 1'b0;
    end
    if (issue_qj_busy && lsb_broadcast && lsb_entry == issue_qj) begin
      fwd_vj      = lsb_result;
      fwd_qj_busy = 1'b0;
    end
    if (issue_qk_busy && alu_broadcast && alu_entry == issue_qk) begin
      fwd_vk      = alu_result;
      fwd_qk_busy = 1'b0;
    end
    if (issue_qk_busy && lsb_broadcast && lsb_entry == issue_qk) begin
      fwd_vk      = lsb_result;
      fwd_qk_busy = 1'b0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in || clear) begin
      busy            <= '0;
      new_calculate   <= 1'b0;
      op_out          <= '0;
      instruction_out <= '0;
      vj_out          <= '0;
      vk_out          <= '0;
      pc_out          <= '0;
      imm_out         <= '0;
      entry_out       <= '0;
    end else if (!rdy_in) begin
      new_calculate <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < RS_SIZE; i++) begin
        if (busy[i]) begin
          if (qj_busy[i] && alu_broadcast && alu_entry == qj[i]) begin
            vj[i]      <= alu_result;
            qj_busy[i] <= 1'b0;
          end
          if (qj_busy[i] && lsb_broadcast && lsb_entry == qj[i]) begin
            vj[i]      <= lsb_result;
            qj_busy[i] <= 1'b0;
          end
          if (qk_busy[i] && alu_broadcast && alu_entry == qk[i]) begin
            vk[i]      <= alu_result;
            qk_busy[i] <= 1'b0;
          end
          if (qk_busy[i] && lsb_broadcast && lsb_entry == qk[i]) begin
            vk[i]      <= lsb_result;
            qk_busy[i] <= 1'b0;
          end
        end
      end

      if (sel_found) begin
        busy[sel_idx]   <= 1'b0;
        new_calculate   <= 1'b1;
        op_out          <= op[sel_idx];
        instruction_out <= instr[sel_idx];
        vj_out          <= vj[sel_idx];
        vk_out          <= vk[sel_idx];
        pc_out          <= pc[sel_idx];
        imm_out         <= imm[sel_idx];
        entry_out       <= dest[sel_idx];
      end else begin
        new_calculate <= 1'b0;
      end

      // free_idx is never the dispatched slot, so a slot freed this edge waits a cycle.
      if (issue_valid && free_found) begin
        busy[free_idx]    <= 1'b1;
        op[free_idx]      <= issue_op;
        instr[free_idx]   <= issue_instruction;
        pc[free_idx]      <= issue_pc;
        imm[free_idx]     <= issue_imm;
        dest[free_idx]    <= issue_entry;
        vj[free_idx]      <= fwd_vj;
        vk[free_idx]      <= fwd_vk;
        qj_busy[free_idx] <= fwd_qj_busy;
        qk_busy[free_idx] <= fwd_qk_busy;
        qj[free_idx]      <= issue_qj;
        qk[free_idx]      <= issue_qk;
      end
    end
  end

endmodule

// File: tb/tb_alu_reservation_station.sv
// Self-checking bench for alu_reservation_station: directed scenarios plus a
// randomized run, all compared against a slot-array reference model.
module tb_alu_reservation_station;
  import alu_reservation_station_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, clear;
  logic        issue_valid;
  logic [5:0]  issue_op;
  logic [31:0] issue_instruction, issue_pc, issue_imm, issue_vj, issue_vk;
  logic        issue_qj_busy, issue_qk_busy;
  logic [3:0]  issue_qj, issue_qk, issue_entry;
  logic        rs_full;
  logic        alu_broadcast, lsb_broadcast;
  logic [31:0] alu_result, lsb_result;
  logic [3:0]  alu_entry, lsb_entry;
  logic        new_calculate;
  logic [5:0]  op_out;
  logic [31:0] instruction_out, vj_out, vk_out, pc_out, imm_out;
  logic [3:0]  entry_out;

  always #5 clk_in = ~clk_in;

  alu_reservation_station #(.RS_SIZE(16), .RS_IDX_W(4), .ROB_TAG_W(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
    .issue_valid(issue_valid), .issue_op(issue_op), .issue_instruction(issue_instruction),
    .issue_pc(issue_pc), .issue_imm(issue_imm), .issue_vj(issue_vj), .issue_vk(issue_vk),
    .issue_qj_busy(issue_qj_busy), .issue_qk_busy(issue_qk_busy),
    .issue_qj(issue_qj), .issue_qk(issue_qk), .issue_entry(issue_entry), .rs_full(rs_full),
    .alu_broadcast(alu_broadcast), .alu_result(alu_result), .alu_entry(alu_entry),
    .lsb_broadcast(lsb_broadcast), .lsb_result(lsb_result), .lsb_entry(lsb_entry),
    .new_calculate(new_calculate), .op_out(op_out), .instruction_out(instruction_out),
    .vj_out(vj_out), .vk_out(vk_out), .pc_out(pc_out), .imm_out(imm_out), .entry_out(entry_out)
  );

  logic [170:0] dut_bundle;
  assign dut_bundle = {new_calculate, op_out, instruction_out, vj_out, vk_out, pc_out, imm_out, entry_out};

  // Reference model: one record per slot, plus the expected output bundle.
  typedef struct {
    bit          busy, pj, pk;
    logic [3:0]  qj, qk, ent;
    logic [31:0] vj, vk, pc, imm, ins;
    logic [5:0]  op;
  } m_ent_t;

  m_ent_t       m [16];
  logic [170:0] m_bundle = '0;
  int           tests = 0;
  int           fails = 0;

  function automatic bit m_full();
    bit f = 1'b1;
    foreach (m[i]) if (!m[i].busy) f = 1'b0;
    return f;
  endfunction

  function automatic void model_step();
    int fr = -1;
    int rd = -1;
    m_ent_t n;
    if (rst_in || clear) begin
      foreach (m[i]) m[i].busy = 1'b0;
      m_bundle = '0;
      return;
    end
    if (!rdy_in) begin
      m_bundle[170] = 1'b0;
      return;
    end
    for (int i = 15; i >= 0; i--) begin
      if (!m[i].busy) fr = i;
      if (m[i].busy && !m[i].pj && !m[i].pk) rd = i;
    end
    if (rd >= 0) begin
      m_bundle = {1'b1, m[rd].op, m[rd].ins, m[rd].vj, m[rd].vk, m[rd].pc, m[rd].imm, m[rd].ent};
      m[rd].busy = 1'b0;
    end else begin
      m_bundle[170] = 1'b0;
    end
    foreach (m[i]) begin
      if (m[i].busy) begin
        if (m[i].pj && alu_broadcast && alu_entry == m[i].qj) begin m[i].vj = alu_result; m[i].pj = 0; end
        if (m[i].pj && lsb_broadcast && lsb_entry == m[i].qj) begin m[i].vj = lsb_result; m[i].pj = 0; end
        if (m[i].pk && alu_broadcast && alu_entry == m[i].qk) begin m[i].vk = alu_result; m[i].pk = 0; end
        if (m[i].pk && lsb_broadcast && lsb_entry == m[i].qk) begin m[i].vk = lsb_result; m[i].pk = 0; end
      end
    end
    if (issue_valid && fr >= 0) begin
      n.busy = 1'b1; n.op = issue_op; n.ins = issue_instruction; n.pc = issue_pc;
      n.imm = issue_imm; n.ent = issue_entry;
      n.pj = issue_qj_busy; n.qj = issue_qj; n.vj = issue_vj;
      n.pk = issue_qk_busy; n.qk = issue_qk; n.vk = issue_vk;
      if (n.pj && alu_broadcast && alu_entry == n.qj) begin n.vj = alu_result; n.pj = 0; end
      if (n.pj && lsb_broadcast && lsb_entry == n.qj) begin n.vj = lsb_result; n.pj = 0; end
      if (n.pk && alu_broadcast && alu_entry == n.qk) begin n.vk = alu_result; n.pk = 0; end
      if (n.pk && lsb_broadcast && lsb_entry == n.qk) begin n.vk = lsb_result; n.pk = 0; end
      m[fr] = n;
    end
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle_inputs();
    rst_in = 0; rdy_in = 1; clear = 0; issue_valid = 0;
    alu_broadcast = 0; lsb_broadcast = 0;
  endtask

  task automatic set_issue(input logic [5:0] op, input logic [31:0] vj, input logic [31:0] vk,
                           input bit pj, input logic [3:0] qj, input bit pk, input logic [3:0] qk,
                           input logic [3:0] ent);
    issue_valid = 1; issue_op = op; issue_vj = vj; issue_vk = vk;
    issue_qj_busy = pj; issue_qj = qj; issue_qk_busy = pk; issue_qk = qk; issue_entry = ent;
    issue_pc = $urandom; issue_imm = $urandom; issue_instruction = $urandom;
  endtask

  task automatic test_reset();
    rst_in = 1; rdy_in = 1; clear = 0; issue_valid = 1; alu_broadcast = 0; lsb_broadcast = 0;
    set_issue(6'(OP_ADD), 1, 2, 0, 0, 0, 0, 1);
    alu_result = 0; lsb_result = 0; alu_entry = 0; lsb_entry = 0;
    tick(); tick();
    idle_inputs();
    tests++; if (new_calculate !== 1'b0) begin fails++; $display("FAIL reset_nc got %0b want 0", new_calculate); end
    tests++; if (dut_bundle !== '0) begin fails++; $display("FAIL reset_bundle got %h want 0", dut_bundle); end
    tests++; if (rs_full !== 1'b0) begin fails++; $display("FAIL reset_full got %0b want 0", rs_full); end
    tick();
    tests++; if (new_calculate !== 1'b0) begin fails++; $display("FAIL reset_no_dispatch got %0b want 0", new_calculate); end
  endtask

  task automatic test_ready_issue();
    set_issue(6'(OP_ADD), 5, 7, 0, 0, 0, 0, 3);
    tick(); idle_inputs();
    tests++; if (new_calculate !== 1'b0) begin fails++; $display("FAIL ready_e0_nc got %0b want 0", new_calculate); end
    tick();
    tests++; if ({new_calculate, op_out, vj_out, vk_out, entry_out} !== {1'b1, 6'(OP_ADD), 32'd5, 32'd7, 4'd3}) begin
      fails++; $display("FAIL ready_e1 got nc=%0b op=%0d vj=%h vk=%h ent=%0d want 1/ADD/5/7/3",
                        new_calculate, op_out, vj_out, vk_out, entry_out); end
    tests++; if (dut_bundle !== m_bundle) begin fails++; $display("FAIL ready_bundle got %h want %h", dut_bundle, m_bundle); end
    tick();
    tests++; if (new_calculate !== 1'b0 || vj_out !== 32'd5) begin
      fails++; $display("FAIL ready_after got nc=%0b vj=%h want 0/5", new_calculate, vj_out); end
  endtask

  task automatic test_wakeup();
    set_issue(6'(OP_SUB), 0, 9, 1, 2, 0, 0, 4);
    tick(); idle_inputs(); tick();
    tests++; if (new_calculate !== 1'b0) begin fails++; $display("FAIL wake_pending_nc got %0b want 0", new_calculate); end
    alu_broadcast = 1; alu_entry = 2; alu_result = 32'h10;
    tick(); idle_inputs();
    tests++; if (new_calculate !== 1'b0) begin fails++; $display("FAIL wake_same_cycle got %0b want 0", new_calculate); end
    tick();
    tests++; if ({new_calculate, op_out, vj_out, vk_out, entry_out} !== {1'b1, 6'(OP_SUB), 32'h10, 32'd9, 4'd4}) begin
      fails++; $display("FAIL wake_dispatch got nc=%0b op=%0d vj=%h vk=%h ent=%0d want 1/SUB/10/9/4",
                        new_calculate, op_out, vj_out, vk_out, entry_out); end
  endtask

  task automatic test_forward();
    set_issue(6'(OP_XOR), 1, 0, 0, 0, 1, 6, 5);
    lsb_broadcast = 1; lsb_entry = 6; lsb_result = 32'hAB;
    tick(); idle_inputs(); tick();
    tests++; if ({new_calculate, vj_out, vk_out, entry_out} !== {1'b1, 32'd1, 32'hAB, 4'd5}) begin
      fails++; $display("FAIL forward got nc=%0b vj=%h vk=%h ent=%0d want 1/1/ab/5",
                        new_calculate, vj_out, vk_out, entry_out); end
  endtask

  task automatic test_full();
    for (int i = 0; i < 16; i++) begin
      set_issue(6'(OP_OR), 0, 32'h100 + i, 1, 4'(i), 0, 0, 4'(i));
      tick();
    end
    idle_inputs();
    tests++; if (rs_full !== 1'b1) begin fails++; $display("FAIL full_set got %0b want 1", rs_full); end
    set_issue(6'(OP_AND), 32'hDEAD, 1, 0, 0, 0, 0, 15);
    tick(); idle_inputs();
    tests++; if (rs_full !== 1'b1 || new_calculate !== 1'b0) begin
      fails++; $display("FAIL full_drop got full=%0b nc=%0b want 1/0", rs_full, new_calculate); end
    alu_broadcast = 1; alu_entry = 9; alu_result = 32'h99;
    tick(); idle_inputs();
    tests++; if (rs_full !== 1'b1) begin fails++; $display("FAIL full_wake got %0b want 1", rs_full); end
    tick();
    tests++; if ({rs_full, new_calculate, vj_out, vk_out, entry_out} !== {1'b0, 1'b1, 32'h99, 32'h109, 4'd9}) begin
      fails++; $display("FAIL full_dispatch got full=%0b nc=%0b vj=%h vk=%h ent=%0d want 0/1/99/109/9",
                        rs_full, new_calculate, vj_out, vk_out, entry_out); end
    set_issue(6'(OP_ADD), 32'h77, 1, 0, 0, 0, 0, 12);
    tick(); idle_inputs();
    tests++; if (rs_full !== 1'b1 || new_calculate !== 1'b0) begin
      fails++; $display("FAIL full_refill got full=%0b nc=%0b want 1/0", rs_full, new_calculate); end
    tick();
    tests++; if ({new_calculate, vj_out, entry_out, rs_full} !== {1'b1, 32'h77, 4'd12, 1'b0}) begin
      fails++; $display("FAIL full_refill_dispatch got nc=%0b vj=%h ent=%0d full=%0b want 1/77/12/0",
                        new_calculate, vj_out, entry_out, rs_full); end
    tests++; if (dut_bundle !== m_bundle) begin fails++; $display("FAIL full_bundle got %h want %h", dut_bundle, m_bundle); end
  endtask

  task automatic test_clear();
    clear = 1; tick(); idle_inputs();
    for (int i = 0; i < 5; i++) begin
      set_issue(6'(OP_SLT), 0, 0, 1, 4'(i + 1), 0, 0, 4'(i));
      tick();
    end
    clear = 1;
    set_issue(6'(OP_ADD), 3, 4, 0, 0, 0, 0, 8);
    tick(); idle_inputs();
    tests++; if (rs_full !== 1'b0 || new_calculate !== 1'b0 || dut_bundle !== '0) begin
      fails++; $display("FAIL clear_state got full=%0b nc=%0b bundle=%h want 0/0/0", rs_full, new_calculate, dut_bundle); end
    for (int i = 0; i < 7; i++) begin
      if (i < 5) begin alu_broadcast = 1; alu_entry = 4'(i + 1); alu_result = $urandom; end
      tick(); idle_inputs();
      tests++; if (new_calculate !== 1'b0) begin fails++; $display("FAIL clear_no_dispatch[%0d] got %0b want 0", i, new_calculate); end
    end
  endtask

  task automatic test_rdy();
    for (int i = 0; i < 3; i++) begin
      set_issue(6'(OP_SRL), 0, 32'(i), 1, 7, 0, 0, 4'(10 + i));
      tick();
    end
    idle_inputs();
    alu_broadcast = 1; alu_entry = 7; alu_result = 32'h5A;
    tick(); idle_inputs();
    for (int i = 0; i < 3; i++) begin
      rdy_in = 0;
      set_issue(6'(OP_ADD), 1, 1, 0, 0, 0, 0, 1);
      lsb_broadcast = 1; lsb_entry = 3; lsb_result = 32'hFF;
      tick();
      tests++; if (new_calculate !== 1'b0 || dut_bundle !== m_bundle) begin
        fails++; $display("FAIL rdy_hold[%0d] got %h want %h", i, dut_bundle, m_bundle); end
    end
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++; if ({new_calculate, vj_out, vk_out, entry_out} !== {1'b1, 32'h5A, 32'(i), 4'(10 + i)}) begin
        fails++; $display("FAIL rdy_resume[%0d] got nc=%0b vj=%h vk=%h ent=%0d want 1/5a/%0d/%0d",
                          i, new_calculate, vj_out, vk_out, entry_out, i, 10 + i); end
    end
    tick();
    tests++; if (new_calculate !== 1'b0) begin fails++; $display("FAIL rdy_drained got %0b want 0", new_calculate); end
  endtask

  task automatic test_random();
    clear = 1; tick(); idle_inputs();
    for (int c = 0; c < 400; c++) begin
      rdy_in = ($urandom % 8) != 0;
      clear  = ($urandom % 64) == 0;
      issue_valid = $urandom % 2;
      issue_op = 6'($urandom % 38);
      issue_vj = $urandom; issue_vk = $urandom;
      issue_qj_busy = $urandom % 2; issue_qk_busy = $urandom % 2;
      issue_qj = 4'($urandom); issue_qk = 4'($urandom); issue_entry = 4'($urandom);
      issue_pc = $urandom; issue_imm = $urandom; issue_instruction = $urandom;
      alu_broadcast = $urandom % 2; alu_entry = 4'($urandom); alu_result = $urandom;
      lsb_broadcast = $urandom % 2; lsb_entry = 4'($urandom); lsb_result = $urandom;
      if (lsb_entry == alu_entry) lsb_entry = alu_entry + 4'd1;
      tick();
      tests++; if (dut_bundle !== m_bundle) begin
        fails++; $display("FAIL random_bundle[%0d] got %h want %h", c, dut_bundle, m_bundle); end
      tests++; if (rs_full !== m_full()) begin
        fails++; $display("FAIL random_full[%0d] got %0b want %0b", c, rs_full, m_full()); end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_ready_issue();
    test_wakeup();
    test_forward();
    test_full();
    test_clear();
    test_rdy();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_reservation_station.md
Name: alu_reservation_station

Overview:
- Issue-side counterpart of the ALU in the Tomasulo core.
- Buffers ALU-class instructions from the dispatcher until both source operands are known.
- Captures operands from the CDB broadcasts (ALU and LSB), then selects one ready entry per cycle.
- Drives the ALU input bundle (new_calculate, op, vj, vk, pc, imm, instruction, entry) from registers.

Parameters:
RS_SIZE, 16, number of entries (power of 2)
RS_IDX_W, 4, log2(RS_SIZE)
ROB_TAG_W, 4, width of ROB tag (matches ENTRY_RANGE)

Ports:
clk_in  in  1  system clock
rst_in  in  1  synchronous active-high reset
rdy_in  in  1  global ready; low = freeze all state
clear  in  1  ROB flush on mispredict
issue_valid  in  1  dispatcher presents an instruction
issue_op  in  6  operation code (operaType encoding)
issue_instruction  in  32  raw instruction (shamt source)
issue_pc  in  32  instruction pc
issue_imm  in  32  sign-extended immediate
issue_vj / issue_vk  in  32 each  operand values
issue_qj_busy / issue_qk_busy  in  1 each  operand pending
issue_qj / issue_qk  in  ROB_TAG_W each  producer tag when busy
issue_entry  in  ROB_TAG_W  destination ROB tag
rs_full  out  1  no free entry
alu_broadcast, alu_result[32], alu_entry[ROB_TAG_W]  in  ALU CDB port
lsb_broadcast, lsb_result[32], lsb_entry[ROB_TAG_W]  in  LSB CDB port
new_calculate  out  1  ALU operands valid this cycle
op_out[6], instruction_out[32], vj_out[32], vk_out[32], pc_out[32], imm_out[32], entry_out[ROB_TAG_W]  out  ALU bundle

Behaviour:
- Reset (or clear): all entries not busy; new_calculate=0; all bundle outputs 0. clear has priority over issue, wakeup and select at the same edge.
- rdy_in=0: no state change. new_calculate is forced 0 at the next edge.
- rs_full: combinational, high iff every entry is busy. issue_valid while rs_full is ignored; the dispatcher must not do this.
- Issue:
  - Writes the lowest-index non-busy entry as sampled at the start of the cycle.
  - A slot freed by dispatch in the same cycle is not reused until the next cycle.
- Issue-time forwarding: if issue_qj_busy and a broadcast in the same cycle matches issue_qj, the entry stores that result with qj cleared. Same rule applies for qk.
- Wakeup: every busy entry with pending qj (or qk) equal to a broadcasting tag captures the result at that edge and clears the pending bit. Both ports may hit the same entry (one per operand) in one cycle.
- Ready: busy, qj not pending, qk not pending.
- Select: each cycle picks the lowest-index ready entry; that entry becomes non-busy at the edge.
  - The bundle registers load its fields with new_calculate=1.
  - With no ready entry, new_calculate=0 and the bundle holds its last values.
- Latency:
  - Operands ready at issue: issue at edge E0, new_calculate high after E1.
  - Woken entry: wakeup at edge Ew, new_calculate high after Ew+1.
  - No same-cycle wakeup-and-dispatch.
- Ordering: oldest-first is not required. Only lowest-index priority is specified.
- Broadcasts with a tag matching no pending operand are ignored.

Decomposition:
- Shared header operaType.v holds:
  - op codes
  - ENTRY_RANGE
  - new macros RS_SIZE and RS_RANGE
- One natural sub-module, rs_priority_encoder: RS_SIZE-bit vector in, lowest set index plus found flag out. It is instantiated twice, once for the free-slot search and once for the ready-slot search.

Test Plan:
- Issue ADD with vj=5, vk=7, both ready, entry=3 -> one cycle later new_calculate=1, op_out=ADD, vj_out=5, vk_out=7, entry_out=3; next cycle new_calculate=0.
- Issue SUB with qj=2 pending -> no dispatch; alu_broadcast with entry 2, result 0x10 -> vj_out=0x10 dispatched the following cycle.
- Same-cycle forwarding: issue with qk=6 while lsb_broadcast has entry 6, result 0xAB -> dispatch one cycle later with vk_out=0xAB.
- Fill 16 entries, all pending -> rs_full=1 and a 17th issue is dropped. Wake entry 9 -> it dispatches; rs_full drops after the dispatch edge, and the next issue lands in slot 9.
- Assert clear with 5 busy entries while issue_valid=1 -> rs_full=0, no new_calculate afterwards, and the issued instruction is discarded.
- Drop rdy_in for 3 cycles with ready entries -> new_calculate=0 and state held; resume -> dispatch continues from the lowest-index ready entry.
